// File: rtl/vending_pkg.sv
// Shared types and constants for the ticket dispense arbiter.
// State enum, destination codes, coin unit and change helpers.
package vending_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_PRINT,
    ST_PAYOUT,
    ST_DONE
  } state_e;

  localparam logic [1:0] DEST_NONE      = 2'b00;
  localparam logic [1:0] DEST_HOWRAH    = 2'b01;
  localparam logic [1:0] DEST_MANIKARAN = 2'b10;
  localparam logic [1:0] DEST_ESPLANADE = 2'b11;

  localparam int COIN_UNIT = 5;

  typedef struct packed {
    logic       win;
    logic [1:0] dest;
    logic [4:0] chg;
  } ticket_t;

  function automatic logic [2:0] coin_count(
    input logic [4:0] chg
  );
    logic [4:0] q;
    q = chg / 5'(COIN_UNIT);
    return q[2:0];
  endfunction

  function automatic logic chg_irregular(
    input logic [4:0] chg
  );
    return (chg % 5'(COIN_UNIT)) != 5'd0;
  endfunction

endpackage

// File: rtl/coin_payout_seq.sv
// Coin payout sequencer: one pulse per coin, COIN_GAP cycles apart.
// last marks the final cycle of the payout window.
module coin_payout_seq
  import vending_pkg::*;
#(
  parameter int COIN_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] count,
  output logic       pulse,
  output logic       last
);

  localparam logic [2:0] GAP_INIT = 3'(COIN_GAP - 1);

  logic [2:0] coins_q, coins_d;
  logic [2:0] gap_q, gap_d;
  logic       pulse_q, pulse_d;

  always_comb begin
    coins_d = coins_q;
    gap_d   = gap_q;
    pulse_d = 1'b0;
    if (load) begin
      coins_d = count;
      gap_d   = GAP_INIT;
      pulse_d = (count != 3'd0);
    end else if (coins_q != 3'd0) begin
      // coins_q counts the coin whose gap is running
      if (gap_q == 3'd0) begin
        coins_d = coins_q - 3'd1;
        gap_d   = GAP_INIT;
        pulse_d = (coins_q > 3'd1);
      end else begin
        gap_d = gap_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coins_q <= 3'd0;
      gap_q   <= 3'd0;
      pulse_q <= 1'b0;
    end else begin
      coins_q <= coins_d;
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
  assign last  = (coins_q == 3'd0) ||
                 ((coins_q == 3'd1) && (gap_q == 3'd0));

endmodule

// File: rtl/ticket_dispense_arbiter.sv
// Two-kiosk round-robin ticket arbiter: grant, print, pay change, done.
// All outputs are registered from the next-state decode.
module ticket_dispense_arbiter
  import vending_pkg::*;
#(
  parameter int PRINT_CYCLES = 4,
  parameter int COIN_GAP     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] dest0,
  input  logic [1:0] dest1,
  input  logic [4:0] change0,
  input  logic [4:0] change1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       err,
  output logic       howrah,
  output logic       manikaran,
  output logic       esplanade,
  output logic       coin5,
  output logic       busy
);

  localparam logic [3:0] PCNT_INIT = 4'(PRINT_CYCLES - 1);

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;
  ticket_t    tkt_q, tkt_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic       err_q, err_d;
  logic       hw_q, hw_d;
  logic       mk_q, mk_d;
  logic       es_q, es_d;
  logic       busy_q, busy_d;

  logic       win;
  logic       load;
  logic       last;

  always_comb begin
    win = ptr_q;
    unique case (1'b1)
      req == 2'b01: win = 1'b0;
      req == 2'b10: win = 1'b1;
      default:      win = ptr_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tkt_d   = tkt_q;
    pcnt_d  = pcnt_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          tkt_d.win  = win;
          tkt_d.dest = win ? dest1 : dest0;
          tkt_d.chg  = win ? change1 : change0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (tkt_q.dest != DEST_NONE) begin
          pcnt_d  = PCNT_INIT;
          state_d = ST_PRINT;
        end else begin
          load    = 1'b1;
          state_d = ST_PAYOUT;
        end
      end
      ST_PRINT: begin
        if (pcnt_q == 4'd0) begin
          load    = 1'b1;
          state_d = ST_PAYOUT;
        end else begin
          pcnt_d = pcnt_q - 4'd1;
        end
      end
      ST_PAYOUT: begin
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        ptr_d   = ~tkt_q.win;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs decoded from the state being entered
  always_comb begin
    gnt_d  = 2'b00;
    done_d = 2'b00;
    err_d  = 1'b0;
    hw_d   = 1'b0;
    mk_d   = 1'b0;
    es_d   = 1'b0;
    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_GRANT)
      gnt_d = {tkt_d.win, ~tkt_d.win};
    if (state_d == ST_PRINT) begin
      hw_d = (tkt_d.dest == DEST_HOWRAH);
      mk_d = (tkt_d.dest == DEST_MANIKARAN);
      es_d = (tkt_d.dest == DEST_ESPLANADE);
    end
    if (state_d == ST_DONE) begin
      done_d = {tkt_q.win, ~tkt_q.win};
      err_d  = (tkt_q.dest == DEST_NONE) ||
               chg_irregular(tkt_q.chg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      tkt_q   <= '0;
      pcnt_q  <= 4'd0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      hw_q    <= 1'b0;
      mk_q    <= 1'b0;
      es_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tkt_q   <= tkt_d;
      pcnt_q  <= pcnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hw_q    <= hw_d;
      mk_q    <= mk_d;
      es_q    <= es_d;
      busy_q  <= busy_d;
    end
  end

  coin_payout_seq #(
    .COIN_GAP(COIN_GAP)
  ) u_payout (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .count(coin_count(tkt_q.chg)),
    .pulse(coin5),
    .last (last)
  );

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign howrah    = hw_q;
  assign manikaran = mk_q;
  assign esplanade = es_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ticket_dispense_arbiter.sv
// Self-checking bench for ticket_dispense_arbiter.
// Expected per-cycle traces come from a service-level model.
module tb_ticket_dispense_arbiter;

  localparam int P = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] dest0 = 2'b00;
  logic [1:0] dest1 = 2'b00;
  logic [4:0] change0 = 5'd0;
  logic [4:0] change1 = 5'd0;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       err;
  logic       howrah;
  logic       manikaran;
  logic       esplanade;
  logic       coin5;
  logic       busy;

  logic [9:0] obs;
  logic       m_ptr = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  assign obs = {gnt, done, err, howrah, manikaran,
                esplanade, coin5, busy};

  always #5 clk = ~clk;

  ticket_dispense_arbiter #(
    .PRINT_CYCLES(P),
    .COIN_GAP    (G)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .dest0    (dest0),
    .dest1    (dest1),
    .change0  (change0),
    .change1  (change1),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .howrah   (howrah),
    .manikaran(manikaran),
    .esplanade(esplanade),
    .coin5    (coin5),
    .busy     (busy)
  );

  // obs bits: gnt[9:8] done[7:6] err[5] howrah[4]
  // manikaran[3] esplanade[2] coin5[1] busy[0]
  // mode: 0 none, 1 random input churn, 2 dest0 -> 10 in PRINT
  task automatic serve(input string name, input int mode);
    logic       w;
    logic [1:0] ld;
    logic [4:0] lc;
    int         n;
    int         len;
    logic [9:0] e;
    logic [9:0] exp_q[$];
    w  = (req == 2'b01) ? 1'b0 : (req == 2'b10) ? 1'b1 : m_ptr;
    ld = w ? dest1 : dest0;
    lc = w ? change1 : change0;
    e = '0;
    e[9:8] = w ? 2'b10 : 2'b01;
    e[0] = 1'b1;
    exp_q.push_back(e);
    if (ld != 2'b00) begin
      for (int k = 0; k < P; k++) begin
        e = '0;
        e[4] = (ld == 2'd1);
        e[3] = (ld == 2'd2);
        e[2] = (ld == 2'd3);
        e[0] = 1'b1;
        exp_q.push_back(e);
      end
    end
    n = int'(lc) / 5;
    len = (n == 0) ? 1 : n * G;
    for (int k = 0; k < len; k++) begin
      e = '0;
      e[1] = (n != 0) && (k % G == 0);
      e[0] = 1'b1;
      exp_q.push_back(e);
    end
    e = '0;
    e[7:6] = w ? 2'b10 : 2'b01;
    e[5] = (ld == 2'b00) || (int'(lc) % 5 != 0);
    e[0] = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cyc%0d: got %b want %b",
                 name, i, obs, exp_q[i]);
      end
      if (mode == 1 && i < exp_q.size() - 1) begin
        dest0   = 2'($urandom_range(0, 3));
        dest1   = 2'($urandom_range(0, 3));
        change0 = 5'($urandom_range(0, 31));
        change1 = 5'($urandom_range(0, 31));
      end
      if (mode == 2 && i == 2) dest0 = 2'b10;
    end
    m_ptr = ~w;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (obs !== 10'd0) begin
      n_fail++;
      $display("FAIL %s idle: got %b want %b",
               name, obs, 10'd0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (obs !== 10'd0) begin
      n_fail++;
      $display("FAIL reset: got %b want %b", obs, 10'd0);
    end
    rst = 1'b0;
    m_ptr = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want %b", obs, 10'd0);
    end
  endtask

  task automatic test_single();
    req = 2'b01; dest0 = 2'b01; change0 = 5'd10;
    serve("single", 0);
    req = 2'b00;
  endtask

  task automatic test_round_robin();
    req = 2'b11;
    dest0 = 2'b10; change0 = 5'd5;
    dest1 = 2'b11; change1 = 5'd0;
    serve("rr_first", 0);
    serve("rr_second", 0);
    serve("rr_third", 0);
    req = 2'b00;
  endtask

  task automatic test_refund();
    req = 2'b10; dest1 = 2'b00; change1 = 5'd20;
    serve("refund", 0);
    req = 2'b00;
  endtask

  task automatic test_odd_change();
    req = 2'b01; dest0 = 2'b11; change0 = 5'd7;
    serve("odd_change", 0);
    req = 2'b00;
  endtask

  task automatic test_reset_mid();
    req = 2'b01; dest0 = 2'b01; change0 = 5'd10;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_mid_gnt: got %b want %b", gnt, 2'b01);
    end
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (howrah !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_mid_print: got %b want 1", howrah);
      end
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (obs !== 10'd0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got %b want %b", obs, 10'd0);
    end
    rst = 1'b0;
    m_ptr = 1'b0;
    serve("rst_mid_restart", 0);
    req = 2'b00;
  endtask

  task automatic test_dest_change();
    req = 2'b01; dest0 = 2'b01; change0 = 5'd0;
    serve("dest_change", 2);
    req = 2'b00;
  endtask

  task automatic test_back_to_back();
    req = 2'b01; dest0 = 2'b00; change0 = 5'd0;
    serve("b2b_first", 0);
    serve("b2b_again", 0);
    req = 2'b00;
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      req     = 2'($urandom_range(1, 3));
      dest0   = 2'($urandom_range(0, 3));
      dest1   = 2'($urandom_range(0, 3));
      change0 = 5'($urandom_range(0, 31));
      change1 = 5'($urandom_range(0, 31));
      serve("random", 1);
    end
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_refund();
    test_odd_change();
    test_reset_mid();
    test_dest_change();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ticket_dispense_arbiter.md
TICKET_DISPENSE_ARBITER -- requirements
Module: ticket_dispense_arbiter

Interface
REQ-001 SHALL have parameter PRINT_CYCLES, default 4: cycles the selected destination line is held per ticket (legal 1..15).
REQ-002 SHALL have parameter COIN_GAP, default 2: cycles from one coin5 pulse to the next (legal 1..7).
REQ-003 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, 2: service request per kiosk front-end, held until that kiosk's done.
REQ-006 SHALL have port dest0 / dest1, input, 2 each: kiosk destination choice (01 howrah, 10 manikaran, 11 esplanade, 00 none).
REQ-007 SHALL have port change0 / change1, input, 5 each: kiosk change owed in rupees.
REQ-008 SHALL have port gnt, output, 2: one-hot, one-cycle pulse when a kiosk is accepted.
REQ-009 SHALL have port done, output, 2: one-hot, one-cycle pulse when a kiosk's service ends.
REQ-010 SHALL have port err, output, 1: one-cycle pulse, coincident with done, when the service was irregular.
REQ-011 SHALL have ports howrah, manikaran, esplanade, output, 1 each: shared printer drive lines.
REQ-012 SHALL have port coin5, output, 1: one-cycle pulse releasing one 5-rupee coin.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, GRANT, PRINT, PAYOUT, DONE.
REQ-015 In IDLE with any req bit set, SHALL go to GRANT on the next edge, choosing the winner by the round-robin pointer.
REQ-016 Round-robin rule: if only one req bit is set, that kiosk wins; if both are set, the kiosk indexed by the pointer wins.
REQ-017 In GRANT, gnt[winner] SHALL be high for exactly one cycle, and the winner's dest and change SHALL be latched on that edge.
REQ-018 From GRANT, SHALL go to PRINT if the latched dest is nonzero, else to PAYOUT.
REQ-019 In PRINT, exactly one printer line SHALL be high (per the latched dest) for PRINT_CYCLES consecutive cycles, then the FSM SHALL go to PAYOUT.
REQ-020 Printer lines SHALL never be high together and SHALL be low outside PRINT.
REQ-021 PAYOUT SHALL issue floor(change/5) coin5 pulses, the first on PAYOUT's first cycle, spaced COIN_GAP cycles apart.
REQ-022 The FSM SHALL go to DONE the cycle after the last pulse's gap expires; with zero coins, PAYOUT SHALL last one cycle.
REQ-023 Coin count SHALL be held in a 3-bit down-counter (max 6 for change 31).
REQ-024 In DONE, done[winner] SHALL be high for one cycle, the pointer SHALL be set to the other kiosk, and the FSM SHALL return to IDLE.
REQ-025 err SHALL pulse in DONE if the latched dest was 00 (refund-only service) or the latched change was not a multiple of 5.
REQ-026 req changes, and dest/change changes, after GRANT SHALL be ignored until DONE.
REQ-027 A kiosk still requesting in the IDLE cycle after its DONE SHALL be served again only if the other kiosk is not requesting.
REQ-028 The minimum service time, for nonzero dest and zero change, SHALL be 1 (GRANT) + PRINT_CYCLES + 1 (PAYOUT) + 1 (DONE) cycles after the IDLE detection edge.

Reset
REQ-029 While rst is high at an edge, the state SHALL be IDLE, the pointer 0, counters and latches 0, and every output 0.
REQ-030 Reset asserted mid-service SHALL abort the service with no done, err or further coin5 or printer activity; after rst falls, the service restarts from IDLE on a held req.

Structure
REQ-031 A shared package vending_pkg SHALL hold the FSM state enum, the destination encodings (DEST_NONE/HOWRAH/MANIKARAN/ESPLANADE), and the COIN_UNIT=5 constant.
REQ-032 The coin payout timing SHALL be one sub-module, coin_payout_seq (load, count, pulse, last).
REQ-033 All other logic SHALL live in the top-level module.

Verification
REQ-034 Scenario: req=01, dest0=01, change0=10 -> gnt=01 one cycle; howrah high 4 cycles; 2 coin5 pulses 2 cycles apart; done=01; err=0.
REQ-035 Scenario: req=11 from reset -> kiosk 0 is served first; kiosk 1 is granted in the IDLE cycle after done[0]; then, with both requesting again, kiosk 0 is served.
REQ-036 Scenario: dest1=00, change1=20 -> PRINT is skipped; 4 coin5 pulses; done=10 with err=1.
REQ-037 Scenario: change0=7, dest0=11 -> esplanade high 4 cycles; 1 coin5 pulse; err=1.
REQ-038 Scenario: rst pulsed during the PRINT of kiosk 0 -> all outputs are 0 the next cycle; no done; with req held, a fresh gnt follows reset release.
REQ-039 Scenario: dest0 changed 01->10 during PRINT -> howrah stays high for the full 4 cycles and manikaran never rises.
